regfile_port_arbiter: RTL and testbench
=======================================

REGFILE_PORT_ARBITER -- requirements
Module: regfile_port_arbiter

Interface
REQ-001 SHALL have parameter HOLD_MAX, default 8: maximum consecutive test-owned cycles before one forced processor cycle.
REQ-002 SHALL have port clock  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have ports p_we/p_wreg/p_ra/p_rb/p_wdata  input  1/5/5/5/32  processor write-enable, write register, read registers A/B and write data.
REQ-005 SHALL have port t_req  input  1  test requester asks for regfile ownership; held high while ownership is wanted.
REQ-006 SHALL have ports t_we/t_wreg/t_ra/t_rb/t_wdata  input  1/5/5/5/32  test-side equivalents of REQ-004.
REQ-007 SHALL have port t_gnt  output  1  test side owns the regfile this cycle.
REQ-008 SHALL have port p_stall  output  1  processor access is not honoured this cycle; processor holds its state.
REQ-009 SHALL have ports r_we/r_wreg/r_ra/r_rb/r_wdata  output  1/5/5/5/32  selected request driven to the regfile.
REQ-010 SHALL have port dump_start  input  1  single-cycle pulse requesting a full register dump.
REQ-011 SHALL have ports dump_busy/dump_valid/dump_idx  output  1/1/5  dump in progress; read addresses on r_ra/r_rb are dump addresses; even register index on r_ra.

Function
REQ-012 SHALL implement FSM states PROC, TEST, FORCE, DUMP; r_* follow processor inputs in PROC and FORCE, test inputs in TEST, dump addresses in DUMP.
REQ-013 SHALL register t_gnt, p_stall, dump_busy, dump_valid and dump_idx (no combinational input-to-output path on these); r_* SHALL be combinational muxes selected by the registered state.
REQ-014 SHALL set t_gnt=1 exactly in TEST; p_stall=1 in TEST and DUMP, else 0; dump_busy=dump_valid=1 exactly in DUMP.
REQ-015 SHALL transition PROC->DUMP on dump_start; else PROC->TEST on t_req; dump_start has priority over t_req when both are high in the same cycle.
REQ-016 SHALL count consecutive TEST cycles; TEST->PROC when t_req drops, TEST->FORCE when count reaches HOLD_MAX; FORCE lasts exactly 1 cycle then goes to PROC; count clears on TEST exit.
REQ-017 SHALL latch dump_start pulses seen in TEST or FORCE into a pending flag and enter DUMP on the first cycle back in PROC; pending then clears.
REQ-018 SHALL ignore dump_start while in DUMP (no queued second dump).
REQ-019 SHALL in DUMP drive r_we=0, r_ra=2k, r_rb=2k+1, dump_idx=2k for k=0..15, one pair per cycle, 16 cycles total, then return to PROC.
REQ-020 SHALL force r_we=0 whenever the owning side's write register is 0 (register 0 is never written).
REQ-021 SHALL keep latency of 1 cycle from t_req rising in PROC to t_gnt high, and 1 cycle from t_req falling to t_gnt low.

Reset
REQ-022 SHALL on reset: state=PROC, t_gnt=0, p_stall=0, dump_busy=0, dump_valid=0, dump_idx=0, hold count=0, pending=0.
REQ-023 SHALL abort an in-progress TEST or DUMP on reset with no further dump cycles and no write issued in the reset cycle (r_we=0 while reset high).

Configuration
REQ-024 SHALL compile the dump sequencer only when macro REGFILE_DUMP_EN is defined; with it, REQ-010/011/015/017-019 apply.
REQ-025 SHALL, without REGFILE_DUMP_EN, keep all ports, ignore dump_start, tie dump_busy/dump_valid/dump_idx to 0, and never reach DUMP.

Verification
REQ-026 SHALL cover: t_req=1 for 3 cycles from PROC, t_we=1 t_wreg=5 t_wdata=0xA5A5A5A5 -> t_gnt high cycles 1-3, r_wreg=5, p_stall=1, then PROC.
REQ-027 SHALL cover: t_req held 20 cycles, HOLD_MAX=8 -> t_gnt pattern 8 high, 1 low (FORCE, p_stall=0), 8 high, 1 low, remainder high.
REQ-028 SHALL cover (REGFILE_DUMP_EN): dump_start pulse in PROC -> 16 cycles dump_valid=1, r_ra/r_rb = 0/1, 2/3 ... 30/31, r_we=0, then PROC.
REQ-029 SHALL cover: dump_start and t_req same cycle -> DUMP first, TEST entered on cycle 17 after dump ends.
REQ-030 SHALL cover: reset asserted on dump cycle 5 -> next cycle PROC, dump_busy=0, dump_idx=0, no further dump addresses.
REQ-031 SHALL cover: p_we=1 p_wreg=0 in PROC -> r_we=0; without REGFILE_DUMP_EN, dump_start pulse -> dump_busy stays 0.

Source files
------------

// File: rtl/regfile_port_arbiter_if.sv
// -----------------------------------------------------------------------------
// regfile_port_arbiter_if
// Bundles every non-clock signal of the register-file port arbiter.
//   processor side : p_we, p_wreg, p_ra, p_rb, p_wdata, p_stall
//   test side      : t_req, t_we, t_wreg, t_ra, t_rb, t_wdata, t_gnt
//   regfile side   : r_we, r_wreg, r_ra, r_rb, r_wdata
//   dump control   : dump_start, dump_busy, dump_valid, dump_idx
// modport master : the environment (processor, test port, regfile, dump client)
// modport slave  : the arbiter itself
// -----------------------------------------------------------------------------
interface regfile_port_arbiter_if;
  logic        p_we;
  logic [4:0]  p_wreg;
  logic [4:0]  p_ra;
  logic [4:0]  p_rb;
  logic [31:0] p_wdata;

  logic        t_req;
  logic        t_we;
  logic [4:0]  t_wreg;
  logic [4:0]  t_ra;
  logic [4:0]  t_rb;
  logic [31:0] t_wdata;

  logic        t_gnt;
  logic        p_stall;

  logic        r_we;
  logic [4:0]  r_wreg;
  logic [4:0]  r_ra;
  logic [4:0]  r_rb;
  logic [31:0] r_wdata;

  logic        dump_start;
  logic        dump_busy;
  logic        dump_valid;
  logic [4:0]  dump_idx;

  modport master (
    output p_we, p_wreg, p_ra, p_rb, p_wdata,
    output t_req, t_we, t_wreg, t_ra, t_rb, t_wdata,
    output dump_start,
    input  t_gnt, p_stall,
    input  r_we, r_wreg, r_ra, r_rb, r_wdata,
    input  dump_busy, dump_valid, dump_idx
  );

  modport slave (
    input  p_we, p_wreg, p_ra, p_rb, p_wdata,
    input  t_req, t_we, t_wreg, t_ra, t_rb, t_wdata,
    input  dump_start,
    output t_gnt, p_stall,
    output r_we, r_wreg, r_ra, r_rb, r_wdata,
    output dump_busy, dump_valid, dump_idx
  );
endinterface

// File: rtl/regfile_port_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_port_arbiter
// Shares one register-file port between the processor and a test requester,
// with an optional full-register dump sequencer.
//   clock : single clock, all state changes on its rising edge
//   reset : synchronous, active-high
//   bus   : regfile_port_arbiter_if.slave (processor/test requests in,
//           selected request to the regfile out, grant/stall/dump status out)
// Parameter HOLD_MAX: consecutive test-owned cycles before one forced
// processor cycle.
// Optional feature: define REGFILE_DUMP_EN to build the dump sequencer. Without
// it dump_start is ignored and dump_busy/dump_valid/dump_idx are tied to 0.
// -----------------------------------------------------------------------------
module regfile_port_arbiter #(
  parameter int HOLD_MAX = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  regfile_port_arbiter_if.slave bus
);

  // Hold counter only needs to reach HOLD_MAX-1 (the last TEST cycle).
  localparam int CNT_W = (HOLD_MAX < 2) ? 1 : $clog2(HOLD_MAX);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_MAX - 1);

  typedef enum logic [1:0] {
    ST_PROC  = 2'd0,
    ST_TEST  = 2'd1,
    ST_FORCE = 2'd2,
    ST_DUMP  = 2'd3
  } state_t;

  state_t           state_r;
  state_t           state_s;
  logic [CNT_W-1:0] hold_cnt_r;
  logic [CNT_W-1:0] hold_cnt_s;
  logic             pending_r;
  logic             pending_s;
  logic             dump_start_s;
  logic [3:0]       dump_cnt_r;
  logic             t_gnt_r;
  logic             p_stall_r;

  logic             sel_we_s;
  logic [4:0]       sel_wreg_s;
  logic [4:0]       sel_ra_s;
  logic [4:0]       sel_rb_s;
  logic [31:0]      sel_wdata_s;

`ifdef REGFILE_DUMP_EN
  logic [3:0]       dump_cnt_s;
  logic             dump_busy_r;
  logic [4:0]       dump_idx_r;

  assign dump_start_s = bus.dump_start;
`else
  logic             unused_dump_start_s;

  assign unused_dump_start_s = bus.dump_start;
  assign dump_start_s        = 1'b0;
  assign dump_cnt_r          = 4'd0;
`endif

  // Next-state logic: ownership arbitration, hold counting, dump pending flag.
  always_comb begin
    state_s    = state_r;
    hold_cnt_s = {CNT_W{1'b0}};
    pending_s  = pending_r;
    case (state_r)
      ST_PROC: begin
`ifdef REGFILE_DUMP_EN
        if (dump_start_s || pending_r) begin
          state_s   = ST_DUMP;
          pending_s = 1'b0;
        end else if (bus.t_req) begin
          state_s = ST_TEST;
        end else begin
          state_s = ST_PROC;
        end
`else
        if (bus.t_req) begin
          state_s = ST_TEST;
        end else begin
          state_s = ST_PROC;
        end
`endif
      end
      ST_TEST: begin
        // A dump requested while the test side owns the port waits for PROC.
        pending_s = pending_r | dump_start_s;
        if (!bus.t_req) begin
          state_s = ST_PROC;
        end else if (hold_cnt_r == HOLD_LAST) begin
          state_s = ST_FORCE;
        end else begin
          state_s    = ST_TEST;
          hold_cnt_s = hold_cnt_r + CNT_W'(1);
        end
      end
      ST_FORCE: begin
        // The forced processor cycle re-arbitrates like PROC so a still-held
        // t_req loses only this one cycle; a pending dump goes via PROC.
        pending_s = pending_r | dump_start_s;
        if (pending_s) begin
          state_s = ST_PROC;
        end else if (bus.t_req) begin
          state_s = ST_TEST;
        end else begin
          state_s = ST_PROC;
        end
      end
      ST_DUMP: begin
`ifdef REGFILE_DUMP_EN
        // dump_start is deliberately not sampled here: no queued second dump.
        if (dump_cnt_r == 4'd15) begin
          if (bus.t_req) begin
            state_s = ST_TEST;
          end else begin
            state_s = ST_PROC;
          end
        end else begin
          state_s = ST_DUMP;
        end
`else
        state_s = ST_PROC;
`endif
      end
      default: begin
        state_s = ST_PROC;
      end
    endcase
  end

  // State register, hold counter, pending flag and registered grant/stall.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r    <= ST_PROC;
      hold_cnt_r <= {CNT_W{1'b0}};
      pending_r  <= 1'b0;
      t_gnt_r    <= 1'b0;
      p_stall_r  <= 1'b0;
    end else begin
      state_r    <= state_s;
      hold_cnt_r <= hold_cnt_s;
      pending_r  <= pending_s;
      t_gnt_r    <= (state_s == ST_TEST);
      p_stall_r  <= (state_s == ST_TEST) || (state_s == ST_DUMP);
    end
  end

`ifdef REGFILE_DUMP_EN
  // Dump pair counter: restarts at 0 on every DUMP entry.
  always_comb begin
    dump_cnt_s = 4'd0;
    if ((state_r == ST_DUMP) && (state_s == ST_DUMP)) begin
      dump_cnt_s = dump_cnt_r + 4'd1;
    end else begin
      dump_cnt_s = 4'd0;
    end
  end

  // Dump counter and registered dump status.
  always_ff @(posedge clock) begin
    if (reset) begin
      dump_cnt_r  <= 4'd0;
      dump_busy_r <= 1'b0;
      dump_idx_r  <= 5'd0;
    end else begin
      dump_cnt_r  <= dump_cnt_s;
      dump_busy_r <= (state_s == ST_DUMP);
      dump_idx_r  <= (state_s == ST_DUMP) ? {dump_cnt_s, 1'b0} : 5'd0;
    end
  end

  assign bus.dump_busy  = dump_busy_r;
  assign bus.dump_valid = dump_busy_r;
  assign bus.dump_idx   = dump_idx_r;
`else
  assign bus.dump_busy  = 1'b0;
  assign bus.dump_valid = 1'b0;
  assign bus.dump_idx   = 5'd0;
`endif

  // Regfile request mux, selected by the registered state only.
  always_comb begin
    sel_we_s    = bus.p_we;
    sel_wreg_s  = bus.p_wreg;
    sel_ra_s    = bus.p_ra;
    sel_rb_s    = bus.p_rb;
    sel_wdata_s = bus.p_wdata;
    case (state_r)
      ST_PROC, ST_FORCE: begin
        sel_we_s    = bus.p_we;
        sel_wreg_s  = bus.p_wreg;
        sel_ra_s    = bus.p_ra;
        sel_rb_s    = bus.p_rb;
        sel_wdata_s = bus.p_wdata;
      end
      ST_TEST: begin
        sel_we_s    = bus.t_we;
        sel_wreg_s  = bus.t_wreg;
        sel_ra_s    = bus.t_ra;
        sel_rb_s    = bus.t_rb;
        sel_wdata_s = bus.t_wdata;
      end
      ST_DUMP: begin
        sel_we_s    = 1'b0;
        sel_wreg_s  = 5'd0;
        sel_ra_s    = {dump_cnt_r, 1'b0};
        sel_rb_s    = {dump_cnt_r, 1'b1};
        sel_wdata_s = 32'd0;
      end
      default: begin
        sel_we_s    = 1'b0;
        sel_wreg_s  = 5'd0;
        sel_ra_s    = 5'd0;
        sel_rb_s    = 5'd0;
        sel_wdata_s = 32'd0;
      end
    endcase
  end

  // Register 0 is never written, and nothing is written during reset.
  assign bus.r_we    = sel_we_s && (sel_wreg_s != 5'd0) && !reset;
  assign bus.r_wreg  = sel_wreg_s;
  assign bus.r_ra    = sel_ra_s;
  assign bus.r_rb    = sel_rb_s;
  assign bus.r_wdata = sel_wdata_s;
  assign bus.t_gnt   = t_gnt_r;
  assign bus.p_stall = p_stall_r;

endmodule

// File: tb/tb_regfile_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_regfile_port_arbiter
// Directed self-checking bench for regfile_port_arbiter (HOLD_MAX = 8).
// Dump scenarios are built only when REGFILE_DUMP_EN is defined; otherwise the
// bench checks that dump_start is ignored.
// -----------------------------------------------------------------------------
module tb_regfile_port_arbiter;

  logic clock;
  logic reset;
  int   errors;
  int   checks;

  regfile_port_arbiter_if bus ();

  regfile_port_arbiter #(.HOLD_MAX(8)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    bus.p_we       = 1'b0;
    bus.p_wreg     = 5'd0;
    bus.p_ra       = 5'd0;
    bus.p_rb       = 5'd0;
    bus.p_wdata    = 32'd0;
    bus.t_req      = 1'b0;
    bus.t_we       = 1'b0;
    bus.t_wreg     = 5'd0;
    bus.t_ra       = 5'd0;
    bus.t_rb       = 5'd0;
    bus.t_wdata    = 32'd0;
    bus.dump_start = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    bus.p_we    = 1'b1;
    bus.p_wreg  = 5'd3;
    bus.p_wdata = 32'h1234_5678;
    reset = 1'b1;
    tick();
    tick();
    checks++; if (bus.t_gnt !== 1'b0) begin errors++; $display("FAIL reset_t_gnt: got %0b want 0", bus.t_gnt); end
    checks++; if (bus.p_stall !== 1'b0) begin errors++; $display("FAIL reset_p_stall: got %0b want 0", bus.p_stall); end
    checks++; if (bus.dump_busy !== 1'b0) begin errors++; $display("FAIL reset_dump_busy: got %0b want 0", bus.dump_busy); end
    checks++; if (bus.dump_valid !== 1'b0) begin errors++; $display("FAIL reset_dump_valid: got %0b want 0", bus.dump_valid); end
    checks++; if (bus.dump_idx !== 5'd0) begin errors++; $display("FAIL reset_dump_idx: got %0d want 0", bus.dump_idx); end
    checks++; if (bus.r_we !== 1'b0) begin errors++; $display("FAIL reset_r_we: got %0b want 0", bus.r_we); end
    reset = 1'b0;
    tick();
    checks++; if (bus.r_we !== 1'b1) begin errors++; $display("FAIL proc_r_we: got %0b want 1", bus.r_we); end
    checks++; if (bus.r_wreg !== 5'd3) begin errors++; $display("FAIL proc_r_wreg: got %0d want 3", bus.r_wreg); end
    checks++; if (bus.r_wdata !== 32'h1234_5678) begin errors++; $display("FAIL proc_r_wdata: got %h want 12345678", bus.r_wdata); end
  endtask

  task automatic test_test_access();
    idle_inputs();
    bus.p_we    = 1'b1;
    bus.p_wreg  = 5'd7;
    bus.p_wdata = 32'h1111_1111;
    bus.t_req   = 1'b1;
    bus.t_we    = 1'b1;
    bus.t_wreg  = 5'd5;
    bus.t_ra    = 5'd12;
    bus.t_wdata = 32'hA5A5_A5A5;
    #1;
    checks++; if (bus.t_gnt !== 1'b0) begin errors++; $display("FAIL access_no_comb_gnt: got %0b want 0", bus.t_gnt); end
    for (int i = 1; i <= 3; i++) begin
      tick();
      checks++; if (bus.t_gnt !== 1'b1) begin errors++; $display("FAIL access_t_gnt cycle %0d: got %0b want 1", i, bus.t_gnt); end
      checks++; if (bus.p_stall !== 1'b1) begin errors++; $display("FAIL access_p_stall cycle %0d: got %0b want 1", i, bus.p_stall); end
      checks++; if (bus.r_wreg !== 5'd5) begin errors++; $display("FAIL access_r_wreg cycle %0d: got %0d want 5", i, bus.r_wreg); end
      checks++; if (bus.r_wdata !== 32'hA5A5_A5A5) begin errors++; $display("FAIL access_r_wdata cycle %0d: got %h want a5a5a5a5", i, bus.r_wdata); end
      checks++; if (bus.r_ra !== 5'd12) begin errors++; $display("FAIL access_r_ra cycle %0d: got %0d want 12", i, bus.r_ra); end
      checks++; if (bus.r_we !== 1'b1) begin errors++; $display("FAIL access_r_we cycle %0d: got %0b want 1", i, bus.r_we); end
    end
    bus.t_req = 1'b0;
    tick();
    checks++; if (bus.t_gnt !== 1'b0) begin errors++; $display("FAIL access_release_t_gnt: got %0b want 0", bus.t_gnt); end
    checks++; if (bus.p_stall !== 1'b0) begin errors++; $display("FAIL access_release_p_stall: got %0b want 0", bus.p_stall); end
    checks++; if (bus.r_wreg !== 5'd7) begin errors++; $display("FAIL access_release_r_wreg: got %0d want 7", bus.r_wreg); end
  endtask

  task automatic test_hold_limit();
    // Observation i is taken after the i-th edge with t_req sampled high for
    // edges 0..19 and low at edge 20: 8 granted, FORCE, 8 granted, FORCE, 2 granted, released.
    logic [20:0] exp_pat;
    logic        exp_bit;
    exp_pat = 21'b0_11_0_11111111_0_11111111;
    idle_inputs();
    bus.p_we   = 1'b1;
    bus.p_wreg = 5'd9;
    bus.t_req  = 1'b1;
    bus.t_we   = 1'b1;
    bus.t_wreg = 5'd2;
    for (int i = 0; i <= 20; i++) begin
      if (i == 20) bus.t_req = 1'b0;
      tick();
      exp_bit = exp_pat[i];
      checks++; if (bus.t_gnt !== exp_bit) begin errors++; $display("FAIL hold_t_gnt obs %0d: got %0b want %0b", i, bus.t_gnt, exp_bit); end
      checks++; if (bus.p_stall !== exp_bit) begin errors++; $display("FAIL hold_p_stall obs %0d: got %0b want %0b", i, bus.p_stall, exp_bit); end
      if (i == 8) begin
        checks++; if (bus.r_wreg !== 5'd9) begin errors++; $display("FAIL hold_force_r_wreg: got %0d want 9", bus.r_wreg); end
      end
    end
  endtask

  task automatic test_reg0_protect();
    idle_inputs();
    bus.p_we   = 1'b1;
    bus.p_wreg = 5'd0;
    #1;
    checks++; if (bus.r_we !== 1'b0) begin errors++; $display("FAIL reg0_proc_r_we: got %0b want 0", bus.r_we); end
    bus.t_req  = 1'b1;
    bus.t_we   = 1'b1;
    bus.t_wreg = 5'd0;
    bus.p_wreg = 5'd6;
    tick();
    checks++; if (bus.r_we !== 1'b0) begin errors++; $display("FAIL reg0_test_r_we: got %0b want 0", bus.r_we); end
    bus.t_req = 1'b0;
    tick();
    checks++; if (bus.r_we !== 1'b1) begin errors++; $display("FAIL reg0_back_r_we: got %0b want 1", bus.r_we); end
  endtask

`ifdef REGFILE_DUMP_EN
  task automatic test_dump();
    idle_inputs();
    bus.p_we   = 1'b1;
    bus.p_wreg = 5'd4;
    bus.p_ra   = 5'd9;
    bus.p_rb   = 5'd10;
    bus.dump_start = 1'b1;
    tick();
    bus.dump_start = 1'b0;
    for (int k = 0; k < 16; k++) begin
      checks++; if (bus.dump_valid !== 1'b1) begin errors++; $display("FAIL dump_valid k=%0d: got %0b want 1", k, bus.dump_valid); end
      checks++; if (bus.dump_busy !== 1'b1) begin errors++; $display("FAIL dump_busy k=%0d: got %0b want 1", k, bus.dump_busy); end
      checks++; if (bus.dump_idx !== 5'(2 * k)) begin errors++; $display("FAIL dump_idx k=%0d: got %0d want %0d", k, bus.dump_idx, 2 * k); end
      checks++; if (bus.r_ra !== 5'(2 * k)) begin errors++; $display("FAIL dump_r_ra k=%0d: got %0d want %0d", k, bus.r_ra, 2 * k); end
      checks++; if (bus.r_rb !== 5'(2 * k + 1)) begin errors++; $display("FAIL dump_r_rb k=%0d: got %0d want %0d", k, bus.r_rb, 2 * k + 1); end
      checks++; if (bus.r_we !== 1'b0) begin errors++; $display("FAIL dump_r_we k=%0d: got %0b want 0", k, bus.r_we); end
      checks++; if (bus.p_stall !== 1'b1) begin errors++; $display("FAIL dump_p_stall k=%0d: got %0b want 1", k, bus.p_stall); end
      bus.dump_start = (k == 3) ? 1'b1 : 1'b0;
      tick();
      bus.dump_start = 1'b0;
    end
    checks++; if (bus.dump_busy !== 1'b0) begin errors++; $display("FAIL dump_end_busy: got %0b want 0", bus.dump_busy); end
    checks++; if (bus.p_stall !== 1'b0) begin errors++; $display("FAIL dump_end_p_stall: got %0b want 0", bus.p_stall); end
    checks++; if (bus.r_ra !== 5'd9) begin errors++; $display("FAIL dump_end_r_ra: got %0d want 9", bus.r_ra); end
    tick();
    checks++; if (bus.dump_busy !== 1'b0) begin errors++; $display("FAIL dump_no_requeue: got %0b want 0", bus.dump_busy); end
  endtask

  task automatic test_dump_vs_treq();
    idle_inputs();
    bus.dump_start = 1'b1;
    bus.t_req      = 1'b1;
    tick();
    bus.dump_start = 1'b0;
    for (int k = 0; k < 16; k++) begin
      checks++; if (bus.dump_busy !== 1'b1) begin errors++; $display("FAIL prio_dump_busy k=%0d: got %0b want 1", k, bus.dump_busy); end
      checks++; if (bus.t_gnt !== 1'b0) begin errors++; $display("FAIL prio_t_gnt k=%0d: got %0b want 0", k, bus.t_gnt); end
      tick();
    end
    checks++; if (bus.t_gnt !== 1'b1) begin errors++; $display("FAIL prio_test_after_dump: got %0b want 1", bus.t_gnt); end
    checks++; if (bus.dump_busy !== 1'b0) begin errors++; $display("FAIL prio_busy_after_dump: got %0b want 0", bus.dump_busy); end
    bus.t_req = 1'b0;
    tick();
    checks++; if (bus.t_gnt !== 1'b0) begin errors++; $display("FAIL prio_release: got %0b want 0", bus.t_gnt); end
  endtask

  task automatic test_dump_reset();
    idle_inputs();
    bus.p_we   = 1'b1;
    bus.p_wreg = 5'd4;
    bus.p_ra   = 5'd17;
    bus.dump_start = 1'b1;
    tick();
    bus.dump_start = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    checks++; if (bus.dump_idx !== 5'd8) begin errors++; $display("FAIL dreset_cycle5_idx: got %0d want 8", bus.dump_idx); end
    reset = 1'b1;
    #1;
    checks++; if (bus.r_we !== 1'b0) begin errors++; $display("FAIL dreset_r_we: got %0b want 0", bus.r_we); end
    tick();
    checks++; if (bus.dump_busy !== 1'b0) begin errors++; $display("FAIL dreset_busy: got %0b want 0", bus.dump_busy); end
    checks++; if (bus.dump_idx !== 5'd0) begin errors++; $display("FAIL dreset_idx: got %0d want 0", bus.dump_idx); end
    checks++; if (bus.r_ra !== 5'd17) begin errors++; $display("FAIL dreset_r_ra: got %0d want 17", bus.r_ra); end
    checks++; if (bus.r_we !== 1'b0) begin errors++; $display("FAIL dreset_r_we_held: got %0b want 0", bus.r_we); end
    reset = 1'b0;
    tick();
    checks++; if (bus.dump_busy !== 1'b0) begin errors++; $display("FAIL dreset_after_busy: got %0b want 0", bus.dump_busy); end
    checks++; if (bus.r_ra !== 5'd17) begin errors++; $display("FAIL dreset_after_r_ra: got %0d want 17", bus.r_ra); end
  endtask

  task automatic test_pending();
    idle_inputs();
    bus.t_req = 1'b1;
    tick();
    bus.dump_start = 1'b1;
    tick();
    bus.dump_start = 1'b0;
    checks++; if (bus.dump_busy !== 1'b0) begin errors++; $display("FAIL pend_in_test_busy: got %0b want 0", bus.dump_busy); end
    tick();
    bus.t_req = 1'b0;
    tick();
    checks++; if (bus.t_gnt !== 1'b0) begin errors++; $display("FAIL pend_proc_t_gnt: got %0b want 0", bus.t_gnt); end
    checks++; if (bus.dump_busy !== 1'b0) begin errors++; $display("FAIL pend_proc_busy: got %0b want 0", bus.dump_busy); end
    tick();
    checks++; if (bus.dump_busy !== 1'b1) begin errors++; $display("FAIL pend_dump_busy: got %0b want 1", bus.dump_busy); end
    checks++; if (bus.dump_idx !== 5'd0) begin errors++; $display("FAIL pend_dump_idx: got %0d want 0", bus.dump_idx); end
    for (int i = 0; i < 16; i++) tick();
    checks++; if (bus.dump_busy !== 1'b0) begin errors++; $display("FAIL pend_cleared: got %0b want 0", bus.dump_busy); end
    tick();
    checks++; if (bus.dump_busy !== 1'b0) begin errors++; $display("FAIL pend_no_repeat: got %0b want 0", bus.dump_busy); end
  endtask
`else
  task automatic test_dump_disabled();
    idle_inputs();
    bus.p_ra       = 5'd21;
    bus.dump_start = 1'b1;
    tick();
    bus.dump_start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++; if (bus.dump_busy !== 1'b0) begin errors++; $display("FAIL nodump_busy obs %0d: got %0b want 0", i, bus.dump_busy); end
      checks++; if (bus.dump_valid !== 1'b0) begin errors++; $display("FAIL nodump_valid obs %0d: got %0b want 0", i, bus.dump_valid); end
      checks++; if (bus.p_stall !== 1'b0) begin errors++; $display("FAIL nodump_p_stall obs %0d: got %0b want 0", i, bus.p_stall); end
      checks++; if (bus.r_ra !== 5'd21) begin errors++; $display("FAIL nodump_r_ra obs %0d: got %0d want 21", i, bus.r_ra); end
      tick();
    end
  endtask
`endif

  initial begin
    errors = 0;
    checks = 0;
    reset  = 1'b1;
    idle_inputs();
    test_reset();
    test_test_access();
    test_hold_limit();
    test_reg0_protect();
`ifdef REGFILE_DUMP_EN
    test_dump();
    test_dump_vs_treq();
    test_dump_reset();
    test_pending();
`else
    test_dump_disabled();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
